uart_os_core: RTL

- Full-duplex UART core, second generation. All logic runs on the system clock `clk`; baud timing comes from an internal tick enable, not a divided clock.
- RX uses N-times oversampling with mid-bit sampling and false-start rejection.
- Supports configurable parity, 1 or 2 stop bits, and separate framing, parity and overrun error flags.
- Sits between the system bus/register logic and the serial pins; replaces the divided-clock UART top.

---
 rtl/uart_os_core.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/uart_os_core.sv
// uart_os_core: full-duplex UART with a shared tick enable and oversampled, mid-bit sampled RX.
// Optional UART_RX_MAJORITY_EN: RX bits are the 2-of-3 vote of the samples around each midpoint.
module uart_os_core #(
    parameter int WORD_LENGHT = 8,
    parameter int FREQUENCY   = 50000000,
    parameter int BAUDRATE    = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Rx_in,
    input  logic [WORD_LENGHT-1:0] Tx_in,
    input  logic                   send,
    input  logic                   clear_interrupt,
    output logic [WORD_LENGHT-1:0] Rx_out,
    output logic                   Tx_out,
    output logic                   new_Rx,
    output logic                   Rx_error,
    output logic                   Parity_error,
    output logic                   Overrun,
    output logic                   Tx_ready
);
    localparam int DIV_RAW = FREQUENCY / (BAUDRATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(WORD_LENGHT);
    localparam bit HAS_PAR = (PARITY_MODE != 0);
    localparam bit ODD_PAR = (PARITY_MODE == 2);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    logic [DW-1:0] div_cnt;
    logic          tick;

    assign tick = (div_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= DW'(DIV - 1);
        else           div_cnt <= div_cnt - 1'b1;
    end

    tx_state_t              tx_state, tx_state_nxt;
    logic                   send_q, tx_accept, tx_bit_end, tx_par, tx_stop_cnt;
    logic [WORD_LENGHT-1:0] tx_shreg;
    logic [OW-1:0]          tx_os_cnt;
    logic [BW-1:0]          tx_bit_cnt;

    assign tx_accept  = send & ~send_q & Tx_ready;
    assign tx_bit_end = tick && (tx_os_cnt == '0);

    // Tx_out decodes straight from the state so an async reset forces the line high at once.
    always_comb begin
        tx_state_nxt = tx_state;
        Tx_out       = 1'b1;
        case (tx_state)
            TX_IDLE:   if (!Tx_ready && tick) tx_state_nxt = TX_START;
            TX_START: begin
                Tx_out = 1'b0;
                if (tx_bit_end) tx_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                Tx_out = tx_shreg[0];
                if (tx_bit_end && tx_bit_cnt == '0) tx_state_nxt = HAS_PAR ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                Tx_out = tx_par;
                if (tx_bit_end) tx_state_nxt = TX_STOP;
            end
            TX_STOP:   if (tx_bit_end && tx_stop_cnt == 1'b0) tx_state_nxt = TX_IDLE;
            default:   tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state    <= TX_IDLE;
            send_q      <= 1'b0;
            Tx_ready    <= 1'b1;
            tx_shreg    <= '0;
            tx_par      <= 1'b0;
            tx_os_cnt   <= '0;
            tx_bit_cnt  <= '0;
            tx_stop_cnt <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            send_q   <= send;
            if (tx_accept) begin
                Tx_ready <= 1'b0;
                tx_shreg <= Tx_in;
                tx_par   <= (^Tx_in) ^ ODD_PAR;
            end
            if (tx_state == TX_STOP && tx_state_nxt == TX_IDLE) Tx_ready <= 1'b1;
            if (tx_state == TX_IDLE) tx_os_cnt <= OW'(OVERSAMPLE - 1);
            else if (tick)           tx_os_cnt <= tx_bit_end ? OW'(OVERSAMPLE - 1) : tx_os_cnt - 1'b1;
            if (tx_state == TX_START && tx_bit_end) tx_bit_cnt <= BW'(WORD_LENGHT - 1);
            if (tx_state == TX_DATA && tx_bit_end) begin
                tx_shreg   <= tx_shreg >> 1;
                tx_bit_cnt <= tx_bit_cnt - 1'b1;
            end
            if (tx_state_nxt == TX_STOP && tx_state != TX_STOP) tx_stop_cnt <= 1'(STOP_BITS - 1);
            else if (tx_state == TX_STOP && tx_bit_end)         tx_stop_cnt <= tx_stop_cnt - 1'b1;
        end
    end

    rx_state_t              rx_state, rx_state_nxt;
    logic                   rx_s1, rx_s2, rx_s3, rx_fall, rx_sample, rx_done, rx_bit, rx_par_bad;
    logic [OW-1:0]          rx_os_cnt;
    logic [BW-1:0]          rx_bit_cnt;
    logic [WORD_LENGHT-1:0] rx_shreg;

`ifdef UART_RX_MAJORITY_EN
    // Decision moves one tick past the midpoint; the two earlier samples are held here.
    localparam logic [OW-1:0] RX_START_LOAD = OW'(OVERSAMPLE / 2);
    logic rx_maj_a, rx_maj_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_maj_a <= 1'b1;
            rx_maj_b <= 1'b1;
        end else if (tick) begin
            if (rx_os_cnt == OW'(2)) rx_maj_a <= rx_s2;
            if (rx_os_cnt == OW'(1)) rx_maj_b <= rx_s2;
        end
    end

    assign rx_bit = (rx_maj_a & rx_maj_b) | (rx_maj_a & rx_s2) | (rx_maj_b & rx_s2);
`else
    localparam logic [OW-1:0] RX_START_LOAD = OW'(OVERSAMPLE / 2 - 1);

    assign rx_bit = rx_s2;
`endif

    assign rx_fall   = rx_s3 & ~rx_s2;
    assign rx_sample = tick && (rx_os_cnt == '0) && (rx_state != RX_IDLE);
    assign rx_done   = rx_sample && (rx_state == RX_STOP);

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:   if (rx_fall) rx_state_nxt = RX_START;
            RX_START:  if (rx_sample) rx_state_nxt = rx_bit ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_sample && rx_bit_cnt == '0) rx_state_nxt = HAS_PAR ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_sample) rx_state_nxt = RX_STOP;
            RX_STOP:   if (rx_sample) rx_state_nxt = RX_IDLE;
            default:   rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state     <= RX_IDLE;
            {rx_s1, rx_s2, rx_s3} <= 3'b111;
            rx_os_cnt    <= '0;
            rx_bit_cnt   <= '0;
            rx_shreg     <= '0;
            rx_par_bad   <= 1'b0;
            Rx_out       <= '0;
            new_Rx       <= 1'b0;
            Rx_error     <= 1'b0;
            Parity_error <= 1'b0;
            Overrun      <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_s1    <= Rx_in;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            if (rx_state == RX_IDLE) rx_os_cnt <= RX_START_LOAD;
            else if (tick)           rx_os_cnt <= (rx_os_cnt == '0) ? OW'(OVERSAMPLE - 1) : rx_os_cnt - 1'b1;
            if (rx_state == RX_IDLE) rx_par_bad <= 1'b0;
            if (rx_state == RX_START && rx_sample) rx_bit_cnt <= BW'(WORD_LENGHT - 1);
            if (rx_state == RX_DATA && rx_sample) begin
                rx_shreg   <= {rx_bit, rx_shreg[WORD_LENGHT-1:1]};
                rx_bit_cnt <= rx_bit_cnt - 1'b1;
            end
            if (rx_state == RX_PARITY && rx_sample) rx_par_bad <= rx_bit ^ (^rx_shreg) ^ ODD_PAR;
            // Completion beats a simultaneous clear; only the old flag state is cleared.
            if (rx_done) begin
                Rx_out       <= rx_shreg;
                new_Rx       <= 1'b1;
                Overrun      <= !clear_interrupt && (Overrun || new_Rx);
                Rx_error     <= (Rx_error && !clear_interrupt) || !rx_bit;
                Parity_error <= (Parity_error && !clear_interrupt) || rx_par_bad;
            end else if (clear_interrupt) begin
                new_Rx       <= 1'b0;
                Rx_error     <= 1'b0;
                Parity_error <= 1'b0;
                Overrun      <= 1'b0;
            end
        end
    end
endmodule
